// File: rtl/pwm_seq.sv
// pwm_seq: steps one PWM channel's compare (B) register through a table of
// duty values at a programmable interval. The CPU configures it through a
// slave register port. The sequencer writes the pwm register bus through a
// req/gnt master port.
// Optional build macro: PWM_SEQ_IRQ_EN adds irq_o, a one-cycle done pulse.
module pwm_seq #(
  parameter int DEPTH = 16,
  parameter int CH_W  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic [31:0] pwm_data_o,
  output logic [31:0] pwm_addr_o,
  output logic        pwm_we_o,
  input  logic        pwm_gnt_i,
  output logic        busy_o
`ifdef PWM_SEQ_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int         IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT
  } state_t;

  // Configuration registers
  logic            loop_q;
  logic [CH_W-1:0] ch_q;
  logic [31:0]     step_q;
  logic [4:0]      len_q;
  logic [31:0]     tbl_q [DEPTH];

  // Sequencer state
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [31:0] pdata_q, pdata_d;
  logic [31:0] paddr_q, paddr_d;
`ifdef PWM_SEQ_IRQ_EN
  logic        irq_q, irq_d;
`endif

  // Register-port decode
  logic [7:0] inner;
  logic       wr_ctrl, wr_step, wr_len, wr_status, tbl_hit, wr_tbl;
  logic       start_req, stop_req;
  logic [3:0] ch4;

  assign inner     = addr_i[23:16];
  assign wr_ctrl   = we_i && (inner == 8'h00);
  assign wr_step   = we_i && (inner == 8'h01);
  assign wr_len    = we_i && (inner == 8'h02);
  assign wr_status = we_i && (inner == 8'h03);
  assign tbl_hit   = (inner[7:4] == 4'h1) && ({1'b0, inner[3:0]} < DEPTH5);
  assign wr_tbl    = we_i && tbl_hit;
  assign start_req = wr_ctrl && data_i[0];
  assign stop_req  = wr_ctrl && data_i[1];
  assign ch4       = 4'(ch_q);

  // CPU-writable configuration, including the duty table
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      loop_q <= 1'b0;
      ch_q   <= '0;
      step_q <= '0;
      len_q  <= '0;
      // NOTE: the table is a register file that must read back 0 after
      // reset, so it is built from resettable flops rather than a RAM.
      for (int k = 0; k < DEPTH; k++) tbl_q[k] <= '0;
    end else begin
      if (wr_ctrl) begin
        loop_q <= data_i[2];
        ch_q   <= data_i[4 +: CH_W];
      end
      if (wr_step) step_q <= data_i;
      if (wr_len) begin
        if (data_i > 32'(DEPTH)) len_q <= DEPTH5;
        else                     len_q <= data_i[4:0];
      end
      if (wr_tbl) tbl_q[inner[IW-1:0]] <= data_i;
    end
  end

  // Helpers for the sequencer: final-entry test, next index, table read
  logic        last;
  logic [3:0]  nidx, rd_idx;
  logic [31:0] tbl_rd, step_eff;

  assign last     = ({1'b0, idx_q} + 5'd1) >= len_q;
  assign nidx     = last ? 4'd0 : idx_q + 4'd1;
  assign rd_idx   = (state_q == ST_WAIT) ? nidx : idx_q;
  assign step_eff = (step_q == 32'd0) ? 32'd1 : step_q;

  // Table read port for the master write data
  always_comb begin
    tbl_rd = '0;
    if ({1'b0, rd_idx} < DEPTH5) tbl_rd = tbl_q[rd_idx[IW-1:0]];
  end

  // Next-state and next-output logic of the sequencer
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    we_d    = we_q;
    pdata_d = pdata_q;
    paddr_d = paddr_q;
`ifdef PWM_SEQ_IRQ_EN
    irq_d   = 1'b0;
`endif
    if (wr_status) done_d = 1'b0;
    if (stop_req) begin
      // A pending ungranted write is dropped; a granted one already happened.
      state_d = ST_IDLE;
      we_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_req && (len_q != 5'd0)) begin
            idx_d   = 4'd0;
            done_d  = 1'b0;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!we_q) begin
            // First cycle after start: present the request.
            we_d    = 1'b1;
            pdata_d = tbl_rd;
            paddr_d = {8'h00, 4'h1, ch4, 16'h0000};
          end else if (pwm_gnt_i) begin
            we_d    = 1'b0;
            cnt_d   = step_eff - 32'd1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
          end else if (last && !loop_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
`ifdef PWM_SEQ_IRQ_EN
            irq_d   = 1'b1;
`endif
          end else begin
            // Request goes out in the same cycle WRITE is entered so grants
            // stay exactly max(STEP,1)+1 cycles apart.
            idx_d   = nidx;
            we_d    = 1'b1;
            pdata_d = tbl_rd;
            paddr_d = {8'h00, 4'h1, ch4, 16'h0000};
            state_d = ST_WRITE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      pdata_q <= '0;
      paddr_q <= '0;
`ifdef PWM_SEQ_IRQ_EN
      irq_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      we_q    <= we_d;
      pdata_q <= pdata_d;
      paddr_q <= paddr_d;
`ifdef PWM_SEQ_IRQ_EN
      irq_q   <= irq_d;
`endif
    end
  end

  assign pwm_we_o   = we_q;
  assign pwm_data_o = pdata_q;
  assign pwm_addr_o = paddr_q;
  assign busy_o     = (state_q != ST_IDLE);
`ifdef PWM_SEQ_IRQ_EN
  assign irq_o      = irq_q;
`endif

  // CPU read mux, combinational from the address
  always_comb begin
    data_o = '0;
    unique case (inner)
      8'h00: data_o = {24'b0, ch4, 1'b0, loop_q, 2'b0};
      8'h01: data_o = step_q;
      8'h02: data_o = {27'b0, len_q};
      8'h03: data_o = {15'b0, done_q, 4'b0, idx_q, 7'b0, busy_o};
      default: if (tbl_hit) data_o = tbl_q[inner[IW-1:0]];
    endcase
  end

endmodule

// File: tb/tb_pwm_seq.sv
// Directed bench for pwm_seq: register map, sequencing, grant hold-off,
// stop, loop, reset mid-run and ignored starts.
module tb_pwm_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_i, addr_i, data_o;
  logic        we_i;
  logic [31:0] pwm_data_o, pwm_addr_o;
  logic        pwm_we_o, pwm_gnt_i, busy_o;
`ifdef PWM_SEQ_IRQ_EN
  logic        irq_o;
`endif

  int total = 0;
  int bad   = 0;

  // Monitor state: cycle counter, request-cycle count, granted-write log
  int          cyc     = 0;
  int          we_cnt  = 0;
  int          irq_cnt = 0;
  logic [31:0] log_d[$];
  logic [31:0] log_a[$];
  int          log_c[$];

  localparam logic [31:0] ADDR_CH2 = 32'h0012_0000;

  pwm_seq dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .data_o     (data_o),
    .pwm_data_o (pwm_data_o),
    .pwm_addr_o (pwm_addr_o),
    .pwm_we_o   (pwm_we_o),
    .pwm_gnt_i  (pwm_gnt_i),
    .busy_o     (busy_o)
`ifdef PWM_SEQ_IRQ_EN
    ,
    .irq_o      (irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Record every completed master write and count request cycles
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (pwm_we_o) we_cnt <= we_cnt + 1;
    if (pwm_we_o && pwm_gnt_i) begin
      log_d.push_back(pwm_data_o);
      log_a.push_back(pwm_addr_o);
      log_c.push_back(cyc);
    end
`ifdef PWM_SEQ_IRQ_EN
    if (irq_o) irq_cnt <= irq_cnt + 1;
`endif
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr_i = {8'h00, a, 16'h0000};
    data_i = d;
    we_i   = 1'b1;
    tick();
    we_i   = 1'b0;
    data_i = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    addr_i = {8'h00, a, 16'h0000};
    #1;
    d = data_o;
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int k = 0;
    while (log_d.size() < n && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (log_d.size() < n) begin
      bad++;
      $display("FAIL %s: timeout, writes=%0d required=%0d", nm, log_d.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (busy_o && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles", nm, budget);
    end
  endtask

  // Compare a granted write in the log against expected data and address
  task automatic chk_write(input int i, input logic [31:0] d, input string nm);
    total++;
    if (log_d.size() <= i || log_d[i] !== d || log_a[i] !== ADDR_CH2) begin
      bad++;
      if (log_d.size() <= i)
        $display("FAIL %s: write %0d missing", nm, i);
      else
        $display("FAIL %s: data=%h addr=%h required data=%h addr=%h",
                 nm, log_d[i], log_a[i], d, ADDR_CH2);
    end
  endtask

  task automatic chk_gap(input int i, input int gap, input string nm);
    total++;
    if (log_c.size() <= i + 1 || (log_c[i+1] - log_c[i]) !== gap) begin
      bad++;
      if (log_c.size() <= i + 1)
        $display("FAIL %s: write %0d missing", nm, i + 1);
      else
        $display("FAIL %s: gap=%0d required=%0d", nm, log_c[i+1] - log_c[i], gap);
    end
  endtask

  task automatic chk_reg(input logic [7:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] v;
    rd(a, v);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL %s: reg %h read=%h required=%h", nm, a, v, exp);
    end
  endtask

  task automatic chk_bit(input logic act, input logic exp, input string nm);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic all_zero(input string nm);
    logic [7:0] regs [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h1f, 8'h20};
    for (int i = 0; i < 8; i++) chk_reg(regs[i], 32'h0, nm);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; we_i = 1'b0; addr_i = '0; data_i = '0; pwm_gnt_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    chk_bit(busy_o, 1'b0, "reset_busy");
    chk_bit(pwm_we_o, 1'b0, "reset_we");
    total++;
    if (pwm_addr_o !== 32'h0 || pwm_data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_master: addr=%h data=%h required 0", pwm_addr_o, pwm_data_o);
    end
    all_zero("reset_regs");
  endtask

  task automatic test_basic();
    int b, t0, ib;
    wr(8'h10, 10); wr(8'h11, 20); wr(8'h12, 30);
    wr(8'h01, 4);  wr(8'h02, 3);  wr(8'h00, 32'h20);
    chk_reg(8'h00, 32'h20, "ctrl_readback");
    chk_reg(8'h11, 20, "table_readback");
    b = log_d.size(); ib = irq_cnt;
    wr(8'h00, 32'h21);
    t0 = cyc - 1;
    wait_log(b + 3, 100, "basic_writes");
    wait_idle(20, "basic_idle");
    total++;
    if (log_c.size() <= b || log_c[b] !== t0 + 2) begin
      bad++;
      $display("FAIL start_latency: first grant at cycle %0d required %0d",
               (log_c.size() > b) ? log_c[b] : -1, t0 + 2);
    end
    chk_write(b,     10, "basic_w0");
    chk_write(b + 1, 20, "basic_w1");
    chk_write(b + 2, 30, "basic_w2");
    chk_gap(b,     5, "basic_gap0");
    chk_gap(b + 1, 5, "basic_gap1");
    chk_reg(8'h03, 32'h0001_0200, "basic_status_done");
`ifdef PWM_SEQ_IRQ_EN
    total++;
    if (irq_cnt - ib !== 1) begin
      bad++;
      $display("FAIL basic_irq: pulses=%0d required=1", irq_cnt - ib);
    end
`endif
    wr(8'h03, 0);
    chk_reg(8'h03, 32'h0000_0200, "status_done_clear");
    wr(8'h02, 100);
    chk_reg(8'h02, 16, "len_clamp");
    wr(8'h02, 3);
  endtask

  task automatic test_loop();
    int b, wb;
    logic [31:0] exp [5] = '{10, 20, 30, 10, 20};
    b = log_d.size();
    wr(8'h00, 32'h25);
    wait_log(b + 5, 200, "loop_writes");
    wr(8'h00, 32'h22);
    wb = we_cnt;
    repeat (20) tick();
    for (int i = 0; i < 5; i++) chk_write(b + i, exp[i], "loop_seq");
    total++;
    if (log_d.size() !== b + 5 || we_cnt !== wb) begin
      bad++;
      $display("FAIL loop_stop: writes=%0d required=%0d req_cycles=%0d required=0",
               log_d.size() - b, 5, we_cnt - wb);
    end
    chk_reg(8'h03, 32'h0000_0100, "loop_stop_status");
  endtask

  task automatic test_gnt_hold();
    int b, k;
    b = log_d.size();
    pwm_gnt_i = 1'b0;
    wr(8'h00, 32'h21);
    k = 0;
    while (!pwm_we_o && k < 10) begin
      tick();
      k++;
    end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (pwm_we_o !== 1'b1 || pwm_addr_o !== ADDR_CH2 || pwm_data_o !== 32'd10) begin
        bad++;
        $display("FAIL gnt_hold cycle %0d: we=%b addr=%h data=%h required we=1 addr=%h data=%h",
                 i, pwm_we_o, pwm_addr_o, pwm_data_o, ADDR_CH2, 32'd10);
      end
      tick();
    end
    total++;
    if (log_d.size() !== b) begin
      bad++;
      $display("FAIL gnt_hold_nogrant: writes=%0d required=0", log_d.size() - b);
    end
    pwm_gnt_i = 1'b1;
    wait_log(b + 3, 100, "gnt_hold_writes");
    chk_write(b, 10, "gnt_hold_w0");
    chk_gap(b, 5, "gnt_hold_gap");
    wait_idle(20, "gnt_hold_idle");
  endtask

  task automatic test_len_step_zero();
    int b, wb;
    wr(8'h02, 0);
    b = log_d.size(); wb = we_cnt;
    wr(8'h00, 32'h21);
    chk_bit(busy_o, 1'b0, "len0_busy");
    repeat (10) tick();
    total++;
    if (we_cnt !== wb || log_d.size() !== b) begin
      bad++;
      $display("FAIL len0_nowrite: req_cycles=%0d required=0", we_cnt - wb);
    end
    wr(8'h01, 0); wr(8'h02, 2);
    b = log_d.size();
    wr(8'h00, 32'h21);
    wait_log(b + 2, 50, "step0_writes");
    chk_write(b,     10, "step0_w0");
    chk_write(b + 1, 20, "step0_w1");
    chk_gap(b, 2, "step0_gap");
    wait_idle(20, "step0_idle");
  endtask

  task automatic test_reset_mid();
    int b;
    wr(8'h01, 4); wr(8'h02, 3);
    b = log_d.size();
    wr(8'h00, 32'h21);
    wait_log(b + 2, 100, "rstmid_writes");
    tick();
    rst_i = 1'b1;
    tick();
    chk_bit(busy_o, 1'b0, "rstmid_busy");
    chk_bit(pwm_we_o, 1'b0, "rstmid_we");
    rst_i = 1'b0;
    all_zero("rstmid_regs");
    wr(8'h10, 5); wr(8'h11, 6); wr(8'h02, 2); wr(8'h01, 1);
    b = log_d.size();
    wr(8'h00, 32'h21);
    wait_log(b + 2, 50, "rstmid_restart");
    chk_write(b,     5, "rstmid_w0");
    chk_write(b + 1, 6, "rstmid_w1");
    wait_idle(20, "rstmid_idle");
    chk_reg(8'h03, 32'h0001_0100, "rstmid_status");
  endtask

  task automatic test_no_restart();
    int b;
    wr(8'h10, 10); wr(8'h11, 20); wr(8'h12, 30);
    wr(8'h02, 3);  wr(8'h01, 10);
    b = log_d.size();
    wr(8'h00, 32'h23);
    repeat (5) tick();
    chk_bit(busy_o, 1'b0, "startstop_busy");
    total++;
    if (log_d.size() !== b) begin
      bad++;
      $display("FAIL startstop_nowrite: writes=%0d required=0", log_d.size() - b);
    end
    wr(8'h00, 32'h21);
    wait_log(b + 2, 100, "busy_start_writes");
    chk_reg(8'h03, 32'h0000_0101, "busy_status_before");
    wr(8'h00, 32'h21);
    tick();
    chk_reg(8'h03, 32'h0000_0101, "busy_status_after");
    wait_log(b + 3, 100, "busy_start_final");
    repeat (30) tick();
    chk_write(b + 2, 30, "busy_start_w2");
    total++;
    if (log_d.size() !== b + 3 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL busy_start_norestart: writes=%0d busy=%b required 3 and 0",
               log_d.size() - b, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_gnt_hold();
    test_len_step_zero();
    test_reset_mid();
    test_no_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_seq.md
Name: pwm_seq

Overview:
- Bus-mapped sequencer that steps the compare (B) register of one PWM channel through a programmed table of duty values at a fixed interval. This produces ramps, breathing and fades without CPU involvement.
- Sits beside the pwm peripheral. The CPU configures it through a slave register port.
- It drives the pwm register bus through a master port with req/gnt, so an external mux can share that bus with the CPU.

Parameters:
- DEPTH, 16, number of duty table entries; 1..16.
- CH_W, 4, width of the target-channel field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- data_i  in  32  CPU write data
- addr_i  in  32  CPU address; inner address = addr_i[23:16]
- we_i  in  1  CPU write strobe
- data_o  out  32  CPU read data, combinational from addr_i
- pwm_data_o  out  32  master write data to pwm
- pwm_addr_o  out  32  master address to pwm
- pwm_we_o  out  1  master write request; held until granted
- pwm_gnt_i  in  1  grant; write completes on a cycle with pwm_we_o && pwm_gnt_i
- busy_o  out  1  sequence running
- irq_o  out  1  done pulse (only with PWM_SEQ_IRQ_EN)

Behaviour:
- Register map (inner address):
  - 0x00 CTRL (W): bit0 start (pulse, not stored); bit1 stop (pulse); bit2 loop (stored); bits[7:4] target channel (stored).
  - 0x01 STEP (RW): 32-bit interval in cycles; 0 treated as 1.
  - 0x02 LEN (RW): [4:0], entries used. Writes are clamped to DEPTH.
  - 0x03 STATUS (R): bit0 busy, bits[11:8] idx, bit16 done (sticky; cleared by a write to 0x03 or by start).
  - 0x10+k TABLE[k] (RW), for k < DEPTH.
  - Unmapped reads return 0.
  - CTRL readback = {24'b0, ch, 1'b0, loop, 2'b0}.
- Reset values: all registers 0, FSM IDLE, idx 0, pwm_we_o 0, pwm_addr_o 0, pwm_data_o 0, busy_o 0, irq_o 0.
- FSM states: IDLE, WRITE, WAIT.
- IDLE:
  - Start with LEN!=0: idx<=0, clear done, go to WRITE on the next cycle.
  - Start with LEN==0 is ignored.
  - Start while busy is ignored.
- WRITE:
  - pwm_we_o=1, pwm_data_o=TABLE[idx], pwm_addr_o={8'h00, 4'h1, ch, 16'h0000}.
  - Outputs are held stable until pwm_gnt_i.
  - On grant: load cnt<=max(STEP,1)-1 and go to WAIT.
- WAIT:
  - If cnt!=0: decrement cnt.
  - Else, if idx==LEN-1:
    - loop=1: idx<=0 and go to WRITE.
    - loop=0: set done, pulse irq, go to IDLE.
  - Else idx<=idx+1 and go to WRITE.
- Timing:
  - Consecutive grants are exactly max(STEP,1)+1 cycles apart when gnt is tied high.
  - CTRL start written at edge T gives pwm_we_o=1 in the cycle after edge T+1.
- Stop (any state): next cycle is IDLE, pwm_we_o=0, done not set. A write already granted stands; a pending ungranted write is dropped.
- Start and stop in the same write: stop wins.
- Live CPU writes during a run:
  - STEP/TABLE writes take effect on the next load/read.
  - Writes to LEN or ch take effect at the next WRITE.
  - If idx>=LEN after a LEN change, treat it as the final entry.
- busy_o = (state!=IDLE).
- rst_i mid-sequence: immediately IDLE, pwm_we_o=0 on the following cycle.

Optional Feature:
- Macro: PWM_SEQ_IRQ_EN.
- Defined: port irq_o exists and is a one-cycle pulse when a non-loop sequence completes. It is never asserted on stop or reset.
- Undefined: irq_o is absent; the STATUS done bit is unchanged.

Test Plan:
- TABLE={10,20,30}, LEN=3, STEP=4, ch=2, gnt=1, start → three writes to addr 0x0012_0000 with data 10,20,30, spaced 5 cycles; then done=1, busy=0, irq pulse once.
- Same setup with loop=1 → data sequence 10,20,30,10,20,…; stop after the 5th write → no further pwm_we_o, done=0.
- gnt held low 7 cycles in WRITE → pwm_we_o, addr and data stable for all 7 cycles; the WAIT count starts only after the grant.
- LEN=0 start → stays IDLE, pwm_we_o never asserted; STEP=0 with LEN=2 → writes 2 cycles apart.
- rst_i asserted during WAIT at idx 1 → busy_o 0 next cycle; all registers read 0; a fresh start begins at idx 0.
- Start+stop in one CTRL write, and start while busy → neither restarts; idx unchanged.
